// File: rtl/sponge_pkg.sv
// Shared sponge definitions: FSM states, default widths and the permutation round helper.
// Build macro SPONGE_ABSORB_PAD_EN adds the PAD state used by 10* padding.
package sponge_pkg;

  localparam int CWIDTH_DEF      = 320;
  localparam int RWIDTH_DEF      = 32;
  localparam int REMAINWIDTH_DEF = 20;
  localparam int ROUND_COUNT_DEF = 10;
  localparam int ROT_AMT         = 7;
  localparam int MAX_SWIDTH      = 1024;

  typedef logic [MAX_SWIDTH-1:0] wide_t;

`ifdef SPONGE_ABSORB_PAD_EN
  typedef enum logic [2:0] {IDLE, WAIT_WORD, PERM_GO, PERM_WAIT, PAD, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_WORD, PERM_GO, PERM_WAIT, DONE} state_t;
`endif

  // Rotate the low w bits of s left by amt; bits at and above w come back as zero.
  function automatic wide_t rotl(input wide_t s, input int amt, input int w);
    wide_t mask;
    wide_t sm;
    mask = {MAX_SWIDTH{1'b1}} >> (MAX_SWIDTH - w);
    sm   = s & mask;
    return ((sm << amt) | (sm >> (w - amt))) & mask;
  endfunction

  function automatic wide_t round_fn(input wide_t s, input int rnd, input int w);
    return rotl(s, ROT_AMT, w) ^ wide_t'(unsigned'(rnd));
  endfunction

endpackage

// File: rtl/sponge_perm.sv
// Iterative sponge permutation: one round per clock, done pulses once after ROUND_COUNT rounds.
module sponge_perm
  import sponge_pkg::*;
#(
  parameter int SWIDTH      = RWIDTH_DEF + CWIDTH_DEF,
  parameter int ROUND_COUNT = ROUND_COUNT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SWIDTH-1:0] s_in,
  output logic [SWIDTH-1:0] s_out,
  output logic              done
);

  localparam int CNTW = $clog2(ROUND_COUNT + 1);
  localparam logic [CNTW-1:0] LAST_ROUND = CNTW'(ROUND_COUNT - 1);

  logic [CNTW-1:0]   round_reg;
  logic              run_reg;
  logic              done_reg;
  logic [SWIDTH-1:0] s_reg;
  logic [SWIDTH-1:0] s_src;
  logic [SWIDTH-1:0] s_next;

  // Round 0 is folded into the start edge so done lands ROUND_COUNT cycles after start.
  always_comb begin
    s_src  = start ? s_in : s_reg;
    s_next = SWIDTH'(round_fn(wide_t'(s_src), start ? 0 : int'(round_reg), SWIDTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round_reg <= '0;
      run_reg   <= 1'b0;
      done_reg  <= 1'b0;
      s_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        s_reg     <= s_next;
        round_reg <= CNTW'(1);
        run_reg   <= (ROUND_COUNT > 1);
        done_reg  <= (ROUND_COUNT == 1);
      end else if (run_reg) begin
        s_reg     <= s_next;
        round_reg <= round_reg + CNTW'(1);
        if (round_reg == LAST_ROUND) begin
          run_reg  <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign s_out = s_reg;
  assign done  = done_reg;

endmodule

// File: rtl/sponge_absorb.sv
// Sponge absorb engine: XORs MSB-aligned message words into the rate, permuting between words.
// Build macro SPONGE_ABSORB_PAD_EN enables 10* padding (inline on a partial word, else a PAD block).
module sponge_absorb
  import sponge_pkg::*;
#(
  parameter int CWIDTH      = CWIDTH_DEF,
  parameter int RWIDTH      = RWIDTH_DEF,
  parameter int REMAINWIDTH = REMAINWIDTH_DEF,
  parameter int ROUND_COUNT = ROUND_COUNT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [RWIDTH-1:0]      r_in,
  input  logic [CWIDTH-1:0]      c_in,
  input  logic [REMAINWIDTH-1:0] msg_len,
  input  logic [RWIDTH-1:0]      m_data,
  input  logic                   m_valid,
  output logic                   m_ready,
  output logic                   busy,
  output logic [RWIDTH-1:0]      r_out,
  output logic [CWIDTH-1:0]      c_out,
  output logic                   done
);

  localparam int SWIDTH = RWIDTH + CWIDTH;
  localparam logic [REMAINWIDTH-1:0] RW_LEN  = REMAINWIDTH'(RWIDTH);
  localparam logic [RWIDTH-1:0]      MSB_BIT = {1'b1, {(RWIDTH-1){1'b0}}};

  state_t                 state_reg;
  logic [RWIDTH-1:0]      r_reg;
  logic [CWIDTH-1:0]      c_reg;
  logic [REMAINWIDTH-1:0] remain_reg;
  logic [RWIDTH-1:0]      r_out_reg;
  logic [CWIDTH-1:0]      c_out_reg;
  logic                   done_reg;

  logic [REMAINWIDTH-1:0] take_len;
  logic [RWIDTH-1:0]      word_mask;
  logic [RWIDTH-1:0]      word_x;
  logic                   perm_start;
  logic                   perm_done;
  logic [SWIDTH-1:0]      perm_out;

`ifdef SPONGE_ABSORB_PAD_EN
  logic                   padded_reg;
  logic                   pad_stage_reg;
  logic                   partial;
  logic [RWIDTH-1:0]      pad_bit;
`endif

  always_comb begin
    take_len  = (remain_reg >= RW_LEN) ? RW_LEN : remain_reg;
    word_mask = ~({RWIDTH{1'b1}} >> take_len);
    word_x    = m_data & word_mask;
`ifdef SPONGE_ABSORB_PAD_EN
    partial   = (take_len < RW_LEN);
    pad_bit   = partial ? (MSB_BIT >> take_len) : '0;
`endif
  end

  assign perm_start = (state_reg == PERM_GO);

  sponge_perm #(
    .SWIDTH      (SWIDTH),
    .ROUND_COUNT (ROUND_COUNT)
  ) u_perm (
    .clk   (clk),
    .reset (reset),
    .start (perm_start),
    .s_in  ({r_reg, c_reg}),
    .s_out (perm_out),
    .done  (perm_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      r_reg         <= '0;
      c_reg         <= '0;
      remain_reg    <= '0;
      r_out_reg     <= '0;
      c_out_reg     <= '0;
      done_reg      <= 1'b0;
`ifdef SPONGE_ABSORB_PAD_EN
      padded_reg    <= 1'b0;
      pad_stage_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            r_reg      <= r_in;
            c_reg      <= c_in;
            remain_reg <= msg_len;
`ifdef SPONGE_ABSORB_PAD_EN
            padded_reg    <= 1'b0;
            pad_stage_reg <= 1'b0;
            state_reg     <= (msg_len != '0) ? WAIT_WORD : PAD;
`else
            state_reg     <= (msg_len != '0) ? WAIT_WORD : DONE;
`endif
          end
        end
        WAIT_WORD: begin
          if (m_valid) begin
`ifdef SPONGE_ABSORB_PAD_EN
            r_reg      <= r_reg ^ word_x ^ pad_bit;
            padded_reg <= padded_reg | partial;
`else
            r_reg      <= r_reg ^ word_x;
`endif
            remain_reg <= remain_reg - take_len;
            state_reg  <= PERM_GO;
          end
        end
        PERM_GO: state_reg <= PERM_WAIT;
        PERM_WAIT: begin
          if (perm_done) begin
            {r_reg, c_reg} <= perm_out;
            if (remain_reg != '0)
              state_reg <= WAIT_WORD;
`ifdef SPONGE_ABSORB_PAD_EN
            else if (!padded_reg)
              state_reg <= PAD;
`endif
            else
              state_reg <= DONE;
          end
        end
`ifdef SPONGE_ABSORB_PAD_EN
        // The pad block spends two cycles here: stage the pad word, then fold it into the rate.
        PAD: begin
          if (!pad_stage_reg) begin
            pad_stage_reg <= 1'b1;
          end else begin
            pad_stage_reg <= 1'b0;
            r_reg         <= r_reg ^ MSB_BIT;
            padded_reg    <= 1'b1;
            state_reg     <= PERM_GO;
          end
        end
`endif
        DONE: begin
          done_reg  <= 1'b1;
          r_out_reg <= r_reg;
          c_out_reg <= c_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_ready = (state_reg == WAIT_WORD);
  assign busy    = (state_reg != IDLE);
  assign r_out   = r_out_reg;
  assign c_out   = c_out_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_sponge_absorb.sv
// Directed self-checking bench for sponge_absorb; covers both SPONGE_ABSORB_PAD_EN builds.
`timescale 1ns/1ps
module tb_sponge_absorb;

  localparam int RW = 32;
  localparam int CW = 320;
  localparam int SW = RW + CW;
  localparam int RC = 10;
  localparam logic [CW-1:0] C0 = {10{32'hA5A5_0F0F}};
  localparam logic [RW-1:0] R0 = 32'h1111_1111;
  localparam logic [RW-1:0] W0 = 32'hDEAD_BEEF;
  localparam logic [RW-1:0] W1 = 32'h0102_0304;
`ifdef SPONGE_ABSORB_PAD_EN
  localparam int TAIL = 2 * RC + 6;
`else
  localparam int TAIL = RC + 3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] r_in = '0;
  logic [CW-1:0] c_in = '0;
  logic [19:0]   msg_len = '0;
  logic [RW-1:0] m_data = '0;
  logic          m_valid = 1'b0;
  logic          m_ready;
  logic          busy;
  logic [RW-1:0] r_out;
  logic [CW-1:0] c_out;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sponge_absorb #(
    .CWIDTH(CW), .RWIDTH(RW), .REMAINWIDTH(20), .ROUND_COUNT(RC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .r_in(r_in), .c_in(c_in),
    .msg_len(msg_len), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .r_out(r_out), .c_out(c_out), .done(done)
  );

  function automatic logic [SW-1:0] perm_model(input logic [SW-1:0] s_init);
    logic [SW-1:0] s;
    s = s_init;
    for (int i = 0; i < RC; i++)
      s = {s[SW-8:0], s[SW-1:SW-7]} ^ SW'(i);
    return s;
  endfunction

  function automatic logic [SW-1:0] exp_two(input logic [RW-1:0] r0, input logic [CW-1:0] c0,
                                            input logic [RW-1:0] w0, input logic [RW-1:0] w1);
    logic [SW-1:0] s;
    s = perm_model({r0 ^ w0, c0});
    s[SW-1:CW] = s[SW-1:CW] ^ w1;
    s = perm_model(s);
`ifdef SPONGE_ABSORB_PAD_EN
    s[SW-1:CW] = s[SW-1:CW] ^ 32'h8000_0000;
    s = perm_model(s);
`endif
    return s;
  endfunction

  // Drives one absorb run; cycle 0 is the start cycle. gap<0 holds m_valid high throughout.
  task automatic run_msg(input logic [RW-1:0] r0, input logic [CW-1:0] c0, input logic [19:0] len,
                         input logic [RW-1:0] w0, input logic [RW-1:0] w1, input int nw,
                         input int gap, input bit poke_start,
                         output int acc0, output int acc1, output int done_t,
                         output bit done_1cyc, output int rdy_cnt);
    int t, wi, rdy_run;
    logic [RW-1:0] words [2];
    words[0] = w0; words[1] = w1;
    acc0 = -1; acc1 = -1; done_t = -1; done_1cyc = 1'b0; rdy_cnt = 0;
    t = 0; wi = 0; rdy_run = 0;
    start = 1'b1; r_in = r0; c_in = c0; msg_len = len; m_valid = 1'b0; m_data = w0;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    while (t < 300 && done_t < 0) begin
      t++;
      if (m_ready) rdy_run++; else rdy_run = 0;
      if (wi < 2) m_data = words[wi];
      m_valid = (wi < nw) && (gap < 0 || rdy_run > gap);
      start = poke_start && (acc0 >= 0) && (t == acc0 + 5);
      if (start) begin
        r_in = '1;
        msg_len = 20'd32;
      end
      @(negedge clk);
      if (m_ready) rdy_cnt++;
      if (m_valid && m_ready) begin
        if (wi == 0) acc0 = t; else acc1 = t;
        wi++;
      end
      if (done) done_t = t;
      @(posedge clk); #1;
    end
    m_valid = 1'b0;
    start = 1'b0;
    if (done_t >= 0) begin
      @(negedge clk);
      done_1cyc = !done;
      @(posedge clk); #1;
    end
    $display("run len=%0d: accepts at %0d,%0d done at %0d r_out=%h", len, acc0, acc1, done_t, r_out);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (m_ready !== 1'b0) begin n_bad++; $display("FAIL reset_m_ready: got %b want 0", m_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (r_out !== '0) begin n_bad++; $display("FAIL reset_r_out: got %h want 0", r_out); end
    n_cmp++; if (c_out !== '0) begin n_bad++; $display("FAIL reset_c_out: got %h want 0", c_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_len0();
    int a0, a1, dt, rc;
    bit d1;
    logic [SW-1:0] want;
    run_msg(32'h1234_5678, '0, 20'd0, '0, '0, 0, -1, 1'b0, a0, a1, dt, d1, rc);
`ifdef SPONGE_ABSORB_PAD_EN
    want = perm_model({32'h9234_5678, {CW{1'b0}}});
    n_cmp++; if (dt !== 2 + TAIL - RC - 3) begin n_bad++; $display("FAIL len0_latency: got %0d want %0d", dt, 2 + TAIL - RC - 3); end
`else
    want = {32'h1234_5678, {CW{1'b0}}};
    n_cmp++; if (dt !== 2) begin n_bad++; $display("FAIL len0_latency: got %0d want 2", dt); end
`endif
    n_cmp++; if (r_out !== want[SW-1:CW]) begin n_bad++; $display("FAIL len0_r_out: got %h want %h", r_out, want[SW-1:CW]); end
    n_cmp++; if (c_out !== want[CW-1:0]) begin n_bad++; $display("FAIL len0_c_out: got %h want %h", c_out, want[CW-1:0]); end
    n_cmp++; if (rc !== 0) begin n_bad++; $display("FAIL len0_m_ready: got %0d ready cycles want 0", rc); end
    n_cmp++; if (d1 !== 1'b1) begin n_bad++; $display("FAIL len0_done_pulse: got %b want 1", d1); end
  endtask

  task automatic test_back_to_back();
    int a0, a1, dt, rc;
    bit d1;
    logic [SW-1:0] want;
    want = exp_two(R0, C0, W0, W1);
    run_msg(R0, C0, 20'd64, W0, W1, 2, -1, 1'b0, a0, a1, dt, d1, rc);
    n_cmp++; if (a1 - a0 !== RC + 2) begin n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", a1 - a0, RC + 2); end
    n_cmp++; if (dt - a1 !== TAIL) begin n_bad++; $display("FAIL b2b_done_latency: got %0d want %0d", dt - a1, TAIL); end
    n_cmp++; if (r_out !== want[SW-1:CW]) begin n_bad++; $display("FAIL b2b_r_out: got %h want %h", r_out, want[SW-1:CW]); end
    n_cmp++; if (c_out !== want[CW-1:0]) begin n_bad++; $display("FAIL b2b_c_out: got %h want %h", c_out, want[CW-1:0]); end
    n_cmp++; if (d1 !== 1'b1) begin n_bad++; $display("FAIL b2b_done_pulse: got %b want 1", d1); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_after: got %b want 0", busy); end
  endtask

`ifdef SPONGE_ABSORB_PAD_EN
  task automatic test_pad_partial();
    int a0, a1, dt, rc;
    bit d1;
    logic [SW-1:0] want;
    want = perm_model({32'hAB80_0000, {CW{1'b0}}});
    run_msg('0, '0, 20'd8, 32'hAB00_00FF, '0, 1, -1, 1'b0, a0, a1, dt, d1, rc);
    n_cmp++; if (dt - a0 !== RC + 3) begin n_bad++; $display("FAIL pad8_latency: got %0d want %0d", dt - a0, RC + 3); end
    n_cmp++; if (r_out !== want[SW-1:CW]) begin n_bad++; $display("FAIL pad8_r_out: got %h want %h", r_out, want[SW-1:CW]); end
    n_cmp++; if (c_out !== want[CW-1:0]) begin n_bad++; $display("FAIL pad8_c_out: got %h want %h", c_out, want[CW-1:0]); end
  endtask

  task automatic test_pad_full();
    int a0, a1, dt, rc;
    bit d1;
    logic [SW-1:0] want;
    want = perm_model({32'hFFFF_FFFF, {CW{1'b0}}});
    want[SW-1:CW] = want[SW-1:CW] ^ 32'h8000_0000;
    want = perm_model(want);
    run_msg('0, '0, 20'd32, 32'hFFFF_FFFF, '0, 1, -1, 1'b0, a0, a1, dt, d1, rc);
    n_cmp++; if (dt - a0 !== 26) begin n_bad++; $display("FAIL pad32_latency: got %0d want 26", dt - a0); end
    n_cmp++; if (r_out !== want[SW-1:CW]) begin n_bad++; $display("FAIL pad32_r_out: got %h want %h", r_out, want[SW-1:CW]); end
    n_cmp++; if (c_out !== want[CW-1:0]) begin n_bad++; $display("FAIL pad32_c_out: got %h want %h", c_out, want[CW-1:0]); end
  endtask
`endif

  task automatic test_reset_mid();
    int t, wi, a1, ndone, a0r, a1r, dt, rc;
    bit d1;
    logic [SW-1:0] want;
    want = exp_two(R0, C0, W0, W1);
    start = 1'b1; r_in = R0; c_in = C0; msg_len = 20'd64; m_data = W0; m_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0; m_valid = 1'b1;
    t = 0; wi = 0; a1 = -1;
    while (t < 100 && a1 < 0) begin
      t++;
      @(negedge clk);
      if (m_ready && m_valid) begin
        if (wi == 0) wi = 1; else a1 = t;
      end
      @(posedge clk); #1;
      if (wi == 1) m_data = W1;
    end
    n_cmp++; if (a1 < 0) begin n_bad++; $display("FAIL rst_second_accept: got timeout want accept"); end
    repeat (3) begin @(posedge clk); #1; end
    m_valid = 1'b0;
    reset = 1'b1;
    #1;
    $display("reset asserted in PERM_WAIT, second accept at %0d", a1);
    n_cmp++; if (m_ready !== 1'b0) begin n_bad++; $display("FAIL rst_m_ready: got %b want 0", m_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (r_out !== '0) begin n_bad++; $display("FAIL rst_r_out: got %h want 0", r_out); end
    n_cmp++; if (c_out !== '0) begin n_bad++; $display("FAIL rst_c_out: got %h want 0", c_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    @(posedge clk); #1;
    n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL rst_no_done: got %0d pulses want 0", ndone); end
    run_msg(R0, C0, 20'd64, W0, W1, 2, -1, 1'b0, a0r, a1r, dt, d1, rc);
    n_cmp++; if (dt - a1r !== TAIL) begin n_bad++; $display("FAIL rst_rerun_latency: got %0d want %0d", dt - a1r, TAIL); end
    n_cmp++; if (r_out !== want[SW-1:CW]) begin n_bad++; $display("FAIL rst_rerun_r_out: got %h want %h", r_out, want[SW-1:CW]); end
    n_cmp++; if (c_out !== want[CW-1:0]) begin n_bad++; $display("FAIL rst_rerun_c_out: got %h want %h", c_out, want[CW-1:0]); end
  endtask

  task automatic test_gaps();
    int a0, a1, dt, rc;
    bit d1;
    logic [SW-1:0] want;
    want = exp_two(R0, C0, W0, W1);
    run_msg(R0, C0, 20'd64, W0, W1, 2, 3, 1'b1, a0, a1, dt, d1, rc);
    n_cmp++; if (a1 - a0 !== RC + 5) begin n_bad++; $display("FAIL gap_spacing: got %0d want %0d", a1 - a0, RC + 5); end
    n_cmp++; if (dt - a1 !== TAIL) begin n_bad++; $display("FAIL gap_done_latency: got %0d want %0d", dt - a1, TAIL); end
    n_cmp++; if (r_out !== want[SW-1:CW]) begin n_bad++; $display("FAIL gap_r_out: got %h want %h", r_out, want[SW-1:CW]); end
    n_cmp++; if (c_out !== want[CW-1:0]) begin n_bad++; $display("FAIL gap_c_out: got %h want %h", c_out, want[CW-1:0]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_len0();
    test_back_to_back();
`ifdef SPONGE_ABSORB_PAD_EN
    test_pad_partial();
    test_pad_full();
`endif
    test_reset_mid();
    test_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sponge_absorb.md
# sponge_absorb

Absorb-phase engine of the sponge construction. It loads an initial rate/capacity state and accepts message words over a valid/ready stream. Each word (MSB-aligned, masked to the remaining length) is XORed into the rate, and the permutation runs between words. The final state is presented to the squeeze stage together with a one-cycle `done` pulse.

## Interface
- `CWIDTH`, 320, capacity width in bits
- `RWIDTH`, 32, rate width in bits; also the message word width
- `REMAINWIDTH`, 20, width of the message bit-length counter
- `ROUND_COUNT`, 10, permutation rounds; one round per clock
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-high
- `start` in 1: begin absorb; sampled only in IDLE
- `r_in` in RWIDTH: initial rate, sampled with `start`
- `c_in` in CWIDTH: initial capacity, sampled with `start`
- `msg_len` in REMAINWIDTH: total message bits, sampled with `start`
- `m_data` in RWIDTH: message word, MSB-aligned
- `m_valid` in 1: `m_data` valid
- `m_ready` out 1: block accepts a word this cycle
- `busy` out 1: high in every state except IDLE
- `r_out` out RWIDTH: final rate, held until the next `start`
- `c_out` out CWIDTH: final capacity, held until the next `start`
- `done` out 1: one-cycle pulse; `r_out`/`c_out` are valid from this cycle

## Operation
- States: IDLE, WAIT_WORD, PERM_GO, PERM_WAIT, PAD, DONE.
- IDLE, `start`=1: load rReg, cReg, remain=`msg_len`, padded=0.
  - If `msg_len`>0, go to WAIT_WORD.
  - If `msg_len`=0, go to PAD when padding is compiled in, otherwise go to DONE.
- WAIT_WORD: `m_ready`=1. On `m_valid`:
  - len = min(remain, RWIDTH).
  - rReg ^= `m_data` masked to its top len bits.
  - remain -= len.
  - Go to PERM_GO.
- PERM_GO: one-cycle `perm_start` to the sub-module carrying {rReg,cReg}. Go to PERM_WAIT.
- PERM_WAIT: on `perm_done`, write back {rReg,cReg}, then:
  - remain>0: go to WAIT_WORD.
  - Padding compiled in and padded=0: go to PAD.
  - Otherwise: go to DONE.
- PAD: rReg ^= 1<<(RWIDTH-1); padded=1; go to PERM_GO.
- DONE: `done`=1; `r_out`/`c_out` <= rReg/cReg; go to IDLE.
- Permutation round i (i=0..ROUND_COUNT-1) on the (RWIDTH+CWIDTH)-bit state s: s = rotl(s,7) ^ i, with i zero-extended into the LSBs. The rate is the MSB part of s.
- `start` outside IDLE is ignored. `m_valid` outside WAIT_WORD is ignored and `m_data` is not consumed.

## Timing
- Reset values: `m_ready`=0, `busy`=0, `done`=0, `r_out`=0, `c_out`=0; internal state IDLE.
- `reset` mid-operation aborts the permutation immediately. Any word in flight is lost and `done` is not pulsed.
- Cycle 0 is the accept cycle. `perm_start` is high in cycle 1. `perm_done` is high in cycle ROUND_COUNT+1. `m_ready` is high again in cycle ROUND_COUNT+2.
- Spacing between acceptances with `m_valid` held high is exactly ROUND_COUNT+2 cycles.
- Final accept to `done` (no PAD): ROUND_COUNT+3 cycles.
- Each PAD block adds ROUND_COUNT+3 cycles.
- `msg_len`=0, no padding: `done` is high 2 cycles after the `start` cycle.
- `m_valid` may drop at any time while `m_ready`=1. The block waits indefinitely.

## Configuration
- Macro `SPONGE_ABSORB_PAD_EN`.
- Defined: 10* padding.
  - A partial final word (len<RWIDTH) also XORs bit RWIDTH-1-len in the same word and sets padded=1.
  - A full final word, or `msg_len`=0, causes an extra PAD block.
- Undefined: no pad logic and no PAD state. The caller supplies padded words, and `msg_len` must be a multiple of RWIDTH.

## Structure
- `sponge_pkg` holds:
  - the state enum;
  - default width constants;
  - the `rotl` function;
  - the round-function helper, shared with the squeeze stage and the bench model.
- One sub-module, `sponge_perm`:
  - ports: `clk`, `reset`, `start`, `s_in`, `s_out`, `done`;
  - internal round counter;
  - `done` is high for one cycle after ROUND_COUNT rounds.

## Test plan
- Without PAD_EN, `msg_len`=0, `r_in`=0x12345678, `c_in`=0 → `done` 2 cycles after `start`, `r_out`=0x12345678, `c_out`=0, `m_ready` never high.
- Without PAD_EN, `msg_len`=64, two words 0xDEADBEEF and 0x01020304 with `m_valid` held high → accepts exactly 12 cycles apart. `r_out`/`c_out` match the package model after two permutations.
- With PAD_EN, `msg_len`=8, word 0xAB000000, state 0 → rate XOR is 0xAB800000, one permutation, `done` 13 cycles after the accept.
- With PAD_EN, `msg_len`=32, word 0xFFFFFFFF → second block XORs 0x80000000, two permutations, `done` 26 cycles after the accept.
- `reset` asserted in PERM_WAIT of the second word → all outputs 0, IDLE. A new `start` then behaves as from power-up.
- `m_valid` toggled 1-0-1 with gaps of 3 idle cycles, plus `start` pulsed while busy → same result as the back-to-back run, and the mid-run `start` has no effect.
